// File: rtl/perf_ctrl.sv
// Performance-counter bank controller: decodes commands into bank strobes and
// streams a snapshot of all counters out over an AXI-Stream style port.
module perf_ctrl #(
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned CNT_N  = 10,
    parameter int unsigned MODE_W = 2
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     cmd_valid_i,
    output logic                     cmd_ready_o,
    input  logic [2:0]               cmd_op_i,
    input  logic [MODE_W-1:0]        cmd_mode_i,

    output logic                     cnt_we_o,
    output logic                     cnt_en_o,
    output logic                     cnt_clear_o,
    output logic                     cnt_save_o,
    output logic [MODE_W-1:0]        cnt_mode_o,
    input  logic [CNT_N*CNT_W-1:0]   cnt_val_i,
    input  logic [CNT_N-1:0]         ovf_i,

    output logic                     m_axis_tvalid_o,
    input  logic                     m_axis_tready_i,
    output logic                     m_axis_tlast_o,
    output logic [CNT_W-1:0]         m_axis_tdata_o,
    output logic                     m_axis_tuser_o,

    output logic                     busy_o,
    output logic                     err_o
);

    localparam int unsigned IDX_W = (CNT_N > 1) ? $clog2(CNT_N) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_LOAD   = 3'd3;
    localparam logic [2:0] ST_STREAM = 3'd4;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_START   = 3'd1;
    localparam logic [2:0] OP_STOP    = 3'd2;
    localparam logic [2:0] OP_CLEAR   = 3'd3;
    localparam logic [2:0] OP_SAVE    = 3'd4;
    localparam logic [2:0] OP_DUMP    = 3'd5;
    localparam logic [2:0] OP_SETMODE = 3'd6;
    localparam logic [2:0] OP_ILLEGAL = 3'd7;

    logic [2:0]        state_q, state_d;
    logic              ready_q;
    logic              en_q;
    logic [MODE_W-1:0] mode_q;
    logic              clear_q;
    logic              save_q;
    logic              dump_q;
    logic              err_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  shadow_q [CNT_N];
    logic [CNT_N-1:0]  ovf_shadow_q;

    logic accept;
    logic beat;
    logic last_idx;
    logic strobe_op;

    assign accept    = cmd_valid_i & ready_q;
    assign beat      = (state_q == ST_STREAM) & m_axis_tready_i;
    assign last_idx  = (idx_q == IDX_W'(CNT_N - 1));
    assign strobe_op = (cmd_op_i != OP_NOP) && (cmd_op_i != OP_ILLEGAL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept && strobe_op) state_d = ST_ISSUE;
            ST_ISSUE:  state_d = dump_q ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_STREAM;
            ST_STREAM: if (beat && last_idx) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            ready_q      <= 1'b0;
            en_q         <= 1'b0;
            mode_q       <= '0;
            clear_q      <= 1'b0;
            save_q       <= 1'b0;
            dump_q       <= 1'b0;
            err_q        <= 1'b0;
            idx_q        <= '0;
            ovf_shadow_q <= '0;
            for (int k = 0; k < CNT_N; k++) begin
                shadow_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            // Ready only after a full cycle spent in IDLE, so each command
            // keeps the port closed for two cycles.
            ready_q <= (state_q == ST_IDLE) && (state_d == ST_IDLE);
            err_q   <= accept && (cmd_op_i == OP_ILLEGAL);

            if (accept) begin
                case (cmd_op_i)
                    OP_START:   en_q   <= 1'b1;
                    OP_STOP:    en_q   <= 1'b0;
                    OP_SETMODE: mode_q <= cmd_mode_i;
                    default:    ;
                endcase
                clear_q <= (cmd_op_i == OP_CLEAR);
                save_q  <= (cmd_op_i == OP_SAVE) || (cmd_op_i == OP_DUMP);
                dump_q  <= (cmd_op_i == OP_DUMP);
            end

            if (state_q == ST_LOAD) begin
                idx_q        <= '0;
                ovf_shadow_q <= ovf_i;
                for (int k = 0; k < CNT_N; k++) begin
                    shadow_q[k] <= cnt_val_i[k*CNT_W +: CNT_W];
                end
            end else if (beat) begin
                idx_q <= last_idx ? '0 : idx_q + IDX_W'(1);
            end
        end
    end

    assign cmd_ready_o     = ready_q;
    assign cnt_we_o        = (state_q == ST_ISSUE);
    assign cnt_clear_o     = (state_q == ST_ISSUE) & clear_q;
    assign cnt_save_o      = (state_q == ST_ISSUE) & save_q;
    assign cnt_en_o        = en_q;
    assign cnt_mode_o      = mode_q;

    assign m_axis_tvalid_o = (state_q == ST_STREAM);
    assign m_axis_tlast_o  = (state_q == ST_STREAM) & last_idx;
    assign m_axis_tdata_o  = shadow_q[idx_q];
    assign m_axis_tuser_o  = ovf_shadow_q[idx_q];

    assign busy_o          = (state_q != ST_IDLE);
    assign err_o           = err_q;

endmodule

// File: doc/perf_ctrl.md
PERF_CTRL -- requirements
Module: perf_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: counter value width.
REQ-002 Parameter CNT_N, default 10: number of counters sequenced.
REQ-003 Parameter MODE_W, default 2: counter mode width.
REQ-004 clk_i  in  1  single clock; all logic rising-edge.
REQ-005 reset_i  in  1  reset, synchronous, active-high.
REQ-006 cmd_valid_i  in  1  command request.
REQ-007 cmd_ready_o  out  1  command accepted when valid&ready.
REQ-008 cmd_op_i  in  3  opcode: 0 NOP, 1 START, 2 STOP, 3 CLEAR, 4 SAVE, 5 DUMP, 6 SETMODE, 7 illegal.
REQ-009 cmd_mode_i  in  MODE_W  mode operand for SETMODE.
REQ-010 cnt_we_o, cnt_en_o, cnt_clear_o, cnt_save_o  out  1 each  counter-bank command strobe and fields.
REQ-011 cnt_mode_o  out  MODE_W  counter-bank mode.
REQ-012 cnt_val_i  in  CNT_N x CNT_W  counter values.
REQ-013 ovf_i  in  CNT_N  counter overflow flags.
REQ-014 m_axis_tvalid_o, m_axis_tready_i, m_axis_tlast_o  out/in/out  1 each  readout stream handshake.
REQ-015 m_axis_tdata_o  out  CNT_W  counter value; m_axis_tuser_o  out  1  overflow flag of same counter.
REQ-016 busy_o  out  1  FSM not IDLE; err_o  out  1  one-cycle pulse on illegal opcode.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, SETTLE, LOAD, STREAM.
REQ-018 cmd_ready_o SHALL be 1 only in IDLE; commands are accepted only when cmd_valid_i&cmd_ready_o.
REQ-019 Internal en_r, mode_r hold levels; cnt_en_o=en_r and cnt_mode_o=mode_r at all times.
REQ-020 START/STOP: set/clear en_r, move to ISSUE.
REQ-021 SETMODE: mode_r<=cmd_mode_i, move to ISSUE.
REQ-022 CLEAR, SAVE, DUMP: move to ISSUE with clear/save flag registered.
REQ-023 ISSUE lasts exactly one cycle: cnt_we_o=1, cnt_clear_o=1 only for CLEAR, cnt_save_o=1 only for SAVE/DUMP; all three strobes 0 in every other state.
REQ-024 After ISSUE, non-DUMP ops return to IDLE; accept-to-cmd_ready_o re-high is 2 cycles.
REQ-025 DUMP: ISSUE -> SETTLE (1 cycle, lets bank register snapshot) -> LOAD.
REQ-026 LOAD (1 cycle) SHALL capture all CNT_N cnt_val_i and ovf_i into shadow registers and set index to 0, then enter STREAM.
REQ-027 STREAM: m_axis_tvalid_o=1; tdata/tuser = shadow[index]; tlast=1 iff index=CNT_N-1.
REQ-028 Index advances only on tvalid&tready; outputs SHALL be held stable while tready=0.
REQ-029 Beat with tlast accepted -> IDLE; exactly CNT_N beats per DUMP, index 0 first.
REQ-030 Shadow contents SHALL not change during STREAM even if cnt_val_i changes.
REQ-031 NOP: accepted, no strobe, remains IDLE.
REQ-032 Opcode 7: accepted, err_o=1 next cycle for one cycle, no strobe, no state change.
REQ-033 Index width = clog2(CNT_N), minimum 1 bit.

Reset
REQ-034 On reset_i=1 at a clock edge: state IDLE, en_r=0, mode_r=0, index=0, shadow=0, all strobes 0, m_axis_tvalid_o=0, err_o=0, busy_o=0; cmd_ready_o=1 the cycle after reset deasserts.
REQ-035 Reset mid-STREAM SHALL abort the dump with no further beats; no tlast is owed.
REQ-036 Reset dominates any simultaneous command or handshake.

Verification
REQ-037 After reset, START -> one cycle cnt_we_o=1, cnt_en_o=1, clear=save=0; cmd_ready_o low exactly 2 cycles.
REQ-038 SETMODE mode=2 then CLEAR -> cnt_mode_o=2 persists; single cnt_clear_o pulse with cnt_we_o, cnt_en_o unchanged.
REQ-039 DUMP with cnt_val_i[k]=k+100, ovf_i=10'h201, tready=1 -> 10 beats 100..109, tuser=1 on beats 0 and 9, tlast on beat 9 only, first tvalid 3 cycles after accept.
REQ-040 DUMP with tready toggling 1/0 and cnt_val_i changed after LOAD -> data stable while stalled, original snapshot values streamed, still 10 beats.
REQ-041 Opcode 7 in IDLE -> err_o single-cycle pulse, no cnt_we_o, cmd_ready_o stays 1.
REQ-042 Reset asserted at beat 4 of DUMP -> tvalid 0 next cycle, en_r=0, next DUMP restarts at index 0.
